// File: rtl/diaosi_types_pkg.sv
// Shared datapath/control types: request-unit state, PC source and write-back mux selects.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DATA  = 2'd1,
    HALT  = 2'd2
  } ru_state_t;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JR     = 2'd3
  } PCSrc_t;

  typedef enum logic [1:0] {
    W_ALU = 2'd0,
    W_MEM = 2'd1,
    W_LUI = 2'd2,
    W_PC4 = 2'd3
  } W_mux_t;

  localparam int RU_TIMEOUT_DEFAULT = 255;

  // A disabled watchdog (timeout 0) still gets a 1-bit counter so the port math stays legal.
  function automatic int ru_wd_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/ru_perf_cnt.sv
// Saturating performance counter with synchronous clear and freeze.
module ru_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             freeze,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !freeze && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/request_unit.sv
// Memory request sequencer between control unit, datapath and memory controller.
// Performance counters are built only when REQUEST_UNIT_PERF_EN is defined.
module request_unit
  import diaosi_types_pkg::*;
#(
  parameter int TIMEOUT = RU_TIMEOUT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cu_iren,
  input  logic             cu_dren,
  input  logic             cu_dwen,
  input  logic             cu_halt,
  input  logic             ihit,
  input  logic             dhit,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halt,
  output logic             fault,
  output logic [CNT_W-1:0] icnt,
  output logic [CNT_W-1:0] istall,
  output logic [CNT_W-1:0] dstall
);

  localparam int WD_W = ru_wd_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam bit WD_ON = (TIMEOUT != 0);

  ru_state_t       state, state_nxt;
  logic            dren_nxt, dwen_nxt, halt_nxt, fault_nxt;
  logic [WD_W-1:0] wd_q, wd_nxt;
  logic            wd_expire;

  // Expiry fires on the TIMEOUT-th DATA cycle without dhit; a dhit that cycle wins.
  assign wd_expire = WD_ON && (wd_q == WD_LAST) && !dhit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= FETCH;
      dmemREN <= 1'b0;
      dmemWEN <= 1'b0;
      halt    <= 1'b0;
      fault   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state   <= state_nxt;
      dmemREN <= dren_nxt;
      dmemWEN <= dwen_nxt;
      halt    <= halt_nxt;
      fault   <= fault_nxt;
      wd_q    <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dren_nxt  = dmemREN;
    dwen_nxt  = dmemWEN;
    halt_nxt  = halt;
    fault_nxt = fault;
    wd_nxt    = wd_q;
    imemREN   = 1'b0;
    pc_en     = 1'b0;
    unique case (state)
      FETCH: begin
        imemREN = cu_iren;
        if (ihit) begin
          if (cu_halt) begin
            state_nxt = HALT;
            halt_nxt  = 1'b1;
          end else if (cu_dren || cu_dwen) begin
            state_nxt = DATA;
            dwen_nxt  = cu_dwen;
            dren_nxt  = cu_dren & ~cu_dwen;
            wd_nxt    = '0;
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          pc_en     = 1'b1;
          dren_nxt  = 1'b0;
          dwen_nxt  = 1'b0;
          state_nxt = FETCH;
        end else if (wd_expire) begin
          dren_nxt  = 1'b0;
          dwen_nxt  = 1'b0;
          fault_nxt = 1'b1;
          halt_nxt  = 1'b1;
          state_nxt = HALT;
        end else if (WD_ON) begin
          wd_nxt = wd_q + WD_W'(1);
        end
      end
      HALT: begin
      end
      default: state_nxt = FETCH;
    endcase
  end

`ifdef REQUEST_UNIT_PERF_EN
  logic frozen;
  logic istall_inc;
  logic dstall_inc;

  assign frozen     = (state == HALT);
  assign istall_inc = (state == FETCH) && imemREN && !ihit;
  assign dstall_inc = (state == DATA) && !dhit;

  ru_perf_cnt #(.CNT_W(CNT_W)) u_icnt (
    .clk(CLK), .rst(RST), .inc(pc_en), .clr(1'b0), .freeze(frozen), .cnt(icnt)
  );
  ru_perf_cnt #(.CNT_W(CNT_W)) u_istall (
    .clk(CLK), .rst(RST), .inc(istall_inc), .clr(1'b0), .freeze(frozen), .cnt(istall)
  );
  ru_perf_cnt #(.CNT_W(CNT_W)) u_dstall (
    .clk(CLK), .rst(RST), .inc(dstall_inc), .clr(1'b0), .freeze(frozen), .cnt(dstall)
  );
`else
  assign icnt   = '0;
  assign istall = '0;
  assign dstall = '0;
`endif

endmodule

// File: tb/tb_request_unit.sv
// Bench for request_unit: directed vector table, corner sequences, random run against a reference model.
module tb_request_unit;

  localparam int TO = 8;
`ifdef REQUEST_UNIT_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic cu_iren = 1'b0, cu_dren = 1'b0, cu_dwen = 1'b0, cu_halt = 1'b0;
  logic ihit = 1'b0, dhit = 1'b0;
  logic imemREN, dmemREN, dmemWEN, pc_en, halt, fault;
  logic [31:0] icnt, istall, dstall;

  request_unit #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .cu_iren(cu_iren), .cu_dren(cu_dren), .cu_dwen(cu_dwen), .cu_halt(cu_halt),
    .ihit(ihit), .dhit(dhit),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .pc_en(pc_en), .halt(halt), .fault(fault),
    .icnt(icnt), .istall(istall), .dstall(dstall)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: pending access kind (0 none, 1 load, 2 store), cycles waited, sticky flags.
  int          m_pend;
  int          m_wait;
  bit          m_halted, m_fault;
  int unsigned m_icnt, m_istall, m_dstall;

  function automatic bit e_imem();
    return !m_halted && (m_pend == 0) && cu_iren;
  endfunction

  function automatic bit e_pc();
    if (m_halted) return 1'b0;
    if (m_pend == 0) return ihit && !cu_halt && !cu_dren && !cu_dwen;
    return dhit;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_wait = 0; m_halted = 0; m_fault = 0;
    m_icnt = 0; m_istall = 0; m_dstall = 0;
  endtask

  task automatic model_step();
    if (PERF && !m_halted) begin
      if (e_pc()) m_icnt = sat_inc(m_icnt);
      if (m_pend == 0 && cu_iren && !ihit) m_istall = sat_inc(m_istall);
      if (m_pend != 0 && !dhit) m_dstall = sat_inc(m_dstall);
    end
    if (!m_halted) begin
      if (m_pend == 0) begin
        if (ihit) begin
          if (cu_halt) m_halted = 1;
          else if (cu_dren || cu_dwen) begin
            m_pend = cu_dwen ? 2 : 1;
            m_wait = 0;
          end
        end
      end else if (dhit) begin
        m_pend = 0;
      end else begin
        m_wait++;
        if (TO != 0 && m_wait == TO) begin
          m_pend = 0; m_fault = 1; m_halted = 1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input bit i_iren, input bit i_dren, input bit i_dwen,
                       input bit i_halt, input bit i_ihit, input bit i_dhit);
    cu_iren = i_iren; cu_dren = i_dren; cu_dwen = i_dwen;
    cu_halt = i_halt; ihit = i_ihit; dhit = i_dhit;
    @(negedge CLK);
  endtask

  task automatic advance();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_model(input string nm);
    chk({nm, " imemREN"}, imemREN, e_imem());
    chk({nm, " dmemREN"}, dmemREN, m_pend == 1);
    chk({nm, " dmemWEN"}, dmemWEN, m_pend == 2);
    chk({nm, " pc_en"},   pc_en,   e_pc());
    chk({nm, " halt"},    halt,    m_halted);
    chk({nm, " fault"},   fault,   m_fault);
    chk({nm, " icnt"},    icnt,    m_icnt);
    chk({nm, " istall"},  istall,  m_istall);
    chk({nm, " dstall"},  dstall,  m_dstall);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cu_iren = 0; cu_dren = 0; cu_dwen = 0; cu_halt = 0; ihit = 0; dhit = 0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit iren, dren, dwen, hlt, ih, dh;
    bit e_imem, e_dr, e_dw, e_pc;
  } vec_t;

  function automatic vec_t mk(input bit iren, input bit dren, input bit dwen, input bit hlt,
                              input bit ih, input bit dh, input bit e_imem, input bit e_dr,
                              input bit e_dw, input bit e_pc);
    vec_t v;
    v.iren = iren; v.dren = dren; v.dwen = dwen; v.hlt = hlt; v.ih = ih; v.dh = dh;
    v.e_imem = e_imem; v.e_dr = e_dr; v.e_dw = e_dw; v.e_pc = e_pc;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    // iren dren dwen hlt ihit dhit | imem dREN dWEN pc_en
    tbl[0]  = mk(1, 0, 0, 0, 1, 0,  1, 0, 0, 1);
    tbl[1]  = mk(1, 0, 0, 0, 1, 0,  1, 0, 0, 1);
    tbl[2]  = mk(1, 0, 0, 0, 1, 0,  1, 0, 0, 1);
    tbl[3]  = mk(1, 1, 0, 0, 1, 0,  1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 1,  0, 1, 0, 1);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    tbl[9]  = mk(1, 1, 1, 0, 1, 0,  1, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 1, 0,  0, 0, 1, 0);
    tbl[11] = mk(1, 0, 0, 0, 1, 1,  0, 0, 1, 1);
    tbl[12] = mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

    model_reset();
    do_reset();
    chk("reset dmemREN", dmemREN, 0);
    chk("reset dmemWEN", dmemWEN, 0);
    chk("reset halt", halt, 0);
    chk("reset fault", fault, 0);

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].iren, tbl[i].dren, tbl[i].dwen, tbl[i].hlt, tbl[i].ih, tbl[i].dh);
      chk($sformatf("vec%0d imemREN", i), imemREN, tbl[i].e_imem);
      chk($sformatf("vec%0d dmemREN", i), dmemREN, tbl[i].e_dr);
      chk($sformatf("vec%0d dmemWEN", i), dmemWEN, tbl[i].e_dw);
      chk($sformatf("vec%0d pc_en", i),   pc_en,   tbl[i].e_pc);
      if (i == 3) chk("vec icnt after 3 alu", icnt, PERF ? 3 : 0);
      if (i == 8) begin
        chk("vec icnt after load", icnt, PERF ? 4 : 0);
        chk("vec dstall after load", dstall, PERF ? 3 : 0);
      end
      advance();
    end
    chk("vec icnt end", icnt, PERF ? 5 : 0);
    chk("vec istall end", istall, PERF ? 2 : 0);
    chk("vec dstall end", dstall, PERF ? 4 : 0);
    chk("vec halt end", halt, 0);

    // Halt is terminal: later ihit/dhit pulses do nothing.
    do_reset();
    apply(1, 0, 0, 0, 1, 0); check_model("pre_halt"); advance();
    apply(1, 0, 0, 1, 1, 0); check_model("halt_ihit"); advance();
    for (int i = 0; i < 5; i++) begin
      apply(1, i[0], 0, 0, 1, 1);
      check_model($sformatf("halted%0d", i));
      chk($sformatf("halted%0d halt", i), halt, 1);
      chk($sformatf("halted%0d pc_en", i), pc_en, 0);
      advance();
    end
    chk("halt icnt frozen", icnt, PERF ? 1 : 0);

    // Watchdog expiry after TO data cycles without dhit.
    do_reset();
    apply(1, 1, 0, 0, 1, 0); check_model("wd_ihit"); advance();
    for (int i = 1; i <= TO; i++) begin
      apply(1, 0, 0, 0, 0, 0);
      check_model($sformatf("wd_data%0d", i));
      chk($sformatf("wd_data%0d dmemREN", i), dmemREN, 1);
      advance();
    end
    apply(1, 0, 0, 0, 1, 1);
    chk("wd_expired dmemREN", dmemREN, 0);
    chk("wd_expired fault", fault, 1);
    chk("wd_expired halt", halt, 1);
    chk("wd_expired imemREN", imemREN, 0);
    check_model("wd_expired");
    advance();

    // dhit on the expiry cycle completes the access instead.
    do_reset();
    apply(1, 1, 0, 0, 1, 0); check_model("wdh_ihit"); advance();
    for (int i = 1; i <= TO; i++) begin
      apply(1, 0, 0, 0, 0, (i == TO));
      check_model($sformatf("wdh_data%0d", i));
      if (i == TO) chk("wdh last pc_en", pc_en, 1);
      advance();
    end
    apply(1, 0, 0, 0, 0, 0);
    chk("wdh after fault", fault, 0);
    chk("wdh after dmemREN", dmemREN, 0);
    chk("wdh after imemREN", imemREN, 1);
    check_model("wdh_after");
    advance();

    // Asynchronous reset in the middle of a store.
    do_reset();
    apply(1, 0, 1, 0, 1, 0); advance();
    apply(1, 0, 0, 0, 0, 0);
    chk("arst pre dmemWEN", dmemWEN, 1);
    chk("arst pre dstall", dstall, 0);
    #2 RST = 1'b1;
    #1;
    chk("arst dmemWEN", dmemWEN, 0);
    chk("arst imemREN follows", imemREN, 1);
    cu_iren = 1'b0;
    #1;
    chk("arst imemREN low", imemREN, 0);
    chk("arst icnt", icnt, 0);
    chk("arst dstall", dstall, 0);
    chk("arst pc_en", pc_en, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        apply($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        check_model($sformatf("rnd%0d", n));
        advance();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/request_unit.md
Name: request_unit

Overview:
- Sequences memory requests on behalf of the control unit, at the opposite end of the control-unit interface.
- Consumes the control unit's decoded i_ren, ru_dren_out, ru_dwen_out and halt.
- Handshakes with the memory controller through ihit/dhit.
- Produces the imemREN, dmemREN and dmemWEN request levels and a one-cycle pc_en completion strobe that advances the PC and regfile write.
- Sits between the control unit, the datapath and the memory controller.

Parameters:
- TIMEOUT, 255, cycles allowed in DATA without dhit before fault. 0 disables the watchdog.
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- cu_iren  in  1  fetch enable from control unit (i_ren).
- cu_dren  in  1  decoded load (ru_dren_out); valid while ihit=1.
- cu_dwen  in  1  decoded store (ru_dwen_out); valid while ihit=1.
- cu_halt  in  1  decoded halt; valid while ihit=1.
- ihit  in  1  instruction word valid this cycle.
- dhit  in  1  data access complete this cycle.
- imemREN  out  1  instruction read request.
- dmemREN  out  1  data read request, registered.
- dmemWEN  out  1  data write request, registered.
- pc_en  out  1  one-cycle instruction-complete strobe.
- halt  out  1  sticky halt, registered.
- fault  out  1  sticky watchdog fault, registered.
- icnt, istall, dstall  out  CNT_W  performance counters (see Optional Feature).

Behaviour:
- Reset: one clock (CLK); reset is asynchronous and active-high (RST). Reset forces the state machine to FETCH.
  - Registered outputs are cleared: dmemREN=0, dmemWEN=0, halt=0, fault=0.
  - Watchdog and performance counters are cleared.
  - Combinational outputs follow the state: imemREN=cu_iren, pc_en=0.
  - Reset asserted mid-access drops any pending request immediately.
- States:
  - FETCH:
    - imemREN=cu_iren.
    - On ihit & cu_halt: go to HALT, halt<=1, pc_en=0.
    - On ihit & (cu_dren|cu_dwen): go to DATA; dmemWEN<=cu_dwen; dmemREN<=cu_dren & ~cu_dwen (store wins if both are set); pc_en=0.
    - On ihit with no data request: pc_en=1 in the same cycle; stay in FETCH.
    - With no ihit: hold.
  - DATA:
    - imemREN=0; dmemREN/dmemWEN held.
    - On dhit: pc_en=1 combinationally in the dhit cycle; dmemREN<=0, dmemWEN<=0; go to FETCH.
    - Request levels are therefore high from the cycle after ihit through the dhit cycle inclusive.
  - HALT:
    - All requests are 0 and pc_en=0; halt=1 until reset.
    - Terminal state; ihit and dhit are ignored.
- Latency:
  - Non-memory instruction: pc_en in the ihit cycle.
  - Memory instruction: at least 2 cycles from ihit to pc_en (dhit at earliest one cycle after ihit).
- Handshake rules:
  - dhit while in FETCH is ignored.
  - ihit while in DATA is ignored.
  - ihit and dhit in the same cycle: only the input relevant to the current state counts.
- Watchdog:
  - The counter clears on entry to DATA and increments each DATA cycle without dhit.
  - If it reaches TIMEOUT with TIMEOUT≠0: both requests drop, fault<=1, halt<=1, go to HALT.
  - A dhit in the same cycle as expiry wins: the access completes normally.
  - Counter width is clog2(TIMEOUT+1); there is no wrap.

Optional Feature:
- REQUEST_UNIT_PERF_EN defined:
  - icnt increments on each pc_en.
  - istall increments on each FETCH cycle with imemREN & ~ihit.
  - dstall increments on each DATA cycle with ~dhit.
  - All counters saturate at all-ones, clear on RST and freeze in HALT.
- Undefined: the ports remain and are driven constant 0; no counter flops are inferred.

Decomposition:
- ru_state_t (FETCH, DATA, HALT; 2-bit enum) goes in diaosi_types_pkg alongside PCSrc_t and W_mux_t.
- The TIMEOUT default constant also goes in diaosi_types_pkg.
- One sub-module, ru_perf_cnt: a saturating CNT_W counter with inc/clr/freeze. It is instantiated three times under REQUEST_UNIT_PERF_EN.

Test Plan:
- Reset release, ihit=1 with no data request for 3 cycles -> pc_en=1 in each of those cycles; dmemREN=dmemWEN=0; icnt=3.
- Load: ihit with cu_dren=1, dhit 4 cycles later -> dmemREN=1 for cycles 1–4 after ihit; pc_en=1 only in the dhit cycle; imemREN=0 during DATA; dstall=3.
- Store and load flags both set at ihit -> dmemWEN=1, dmemREN=0; dhit clears both; FETCH resumes with imemREN=1.
- ihit with cu_halt=1 -> halt=1 next cycle; later ihit/dhit pulses produce no pc_en; halt stays 1 until RST.
- TIMEOUT=8, load with no dhit -> after 8 DATA cycles dmemREN=0, fault=1, halt=1. Repeat with dhit on cycle 8 -> normal pc_en, fault=0.
- RST asserted while in DATA with dmemWEN=1 -> dmemWEN=0 asynchronously; imemREN follows cu_iren; counters=0.
